// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder block.
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding
//   - width of the latency counter
//   - f3_illegal(): funct3 codes that are never legal for the given direction
package mem_resp_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for the largest legal LATENCY (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Reserved codes are always illegal. The unsigned widths only make sense for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and mem_responder.
// Ports:
//   req_valid/req_ready            request handshake
//   req_we, req_addr, req_wdata    store flag, byte address, right-aligned store data
//   req_funct3                     RV32I width code
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             extended load data, rejection flag
// Modports:
//   master  requester side
//   slave   mem_responder side
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ls_align.sv
// Combinational lane logic for byte/half/word accesses to a 32-bit memory word.
// Ports:
//   funct3     in   width code
//   addr_lo    in   byte offset within the word
//   wdata      in   right-aligned store data
//   rword      in   addressed memory word
//   byte_en    out  store byte enables
//   wdata_rep  out  store data replicated into every lane
//   rdata_ext  out  extracted and extended load data
//   misalign   out  half or word access that is not naturally aligned
module ls_align
  import mem_resp_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte     = rword[8*addr_lo +: 8];
    rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = '0;
    misalign  = 1'b0;
    // funct3[2] selects zero extension; funct3[1:0] selects the width.
    case (funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      2'b01: begin
        misalign  = addr_lo[0];
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      2'b10: begin
        misalign  = (addr_lo != 2'b00);
        byte_en   = 4'b1111;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts a load/store, waits LATENCY
// cycles, then commits the store or samples the load and presents a response
// that is held until consumed.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-low reset
//   bus  slave modport of mem_responder_if
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  logic [31:0] mem [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       funct3_q, funct3_d;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_funct3;
  logic [AW-1:0] idx;
  logic [31:0] rword, wdata_rep, rdata_ext;
  logic [3:0]  byte_en;
  logic        misalign, out_of_range, req_err, enter_resp, commit;

  // With LATENCY=0 the response is formed on the accepting edge, before the
  // request has been captured, so the live bus fields are used in IDLE.
  always_comb begin
    cur_we       = (state_q == ST_IDLE) ? bus.req_we     : we_q;
    cur_addr     = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
    cur_wdata    = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;
    cur_funct3   = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;
    idx          = cur_addr[AW+1:2];
    rword        = mem[idx];
    out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    req_err      = misalign | out_of_range | f3_illegal(cur_funct3, cur_we);
  end

  ls_align u_align (
    .funct3   (cur_funct3),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .rword    (rword),
    .byte_en  (byte_en),
    .wdata_rep(wdata_rep),
    .rdata_ext(rdata_ext),
    .misalign (misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    enter_resp  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          funct3_d    = bus.req_funct3;
          req_ready_d = 1'b0;
          if (LAT_C == '0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_C;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) enter_resp = 1'b1;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_rdata_d = (req_err || cur_we) ? '0 : rdata_ext;
    end
  end

  assign commit = enter_resp && cur_we && !req_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Captured request fields are only meaningful outside IDLE; no reset needed.
  always_ff @(posedge clk) begin
    we_q     <= we_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    funct3_q <= funct3_d;
  end

  // Reset on the commit edge suppresses the store; contents are never cleared.
  always_ff @(posedge clk) begin
    if (rst && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance with rsp_ready held high.
  task automatic txn2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                      output int lat);
    int n;
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = addr;
    bus2.req_wdata = wdata; bus2.req_funct3 = f3; bus2.rsp_ready = 1'b1;
    n = 0;
    while (bus2.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 1'b0;
    lat = 1;
    while (bus2.rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    rdata = bus2.rsp_rdata;
    err   = bus2.rsp_err;
    @(posedge clk);
  endtask

  task automatic run2(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn2(we, addr, wdata, f3, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] held;
    int n;
    bus2.req_valid = 0; bus2.req_we = 0; bus2.req_addr = 0; bus2.req_wdata = 0;
    bus2.req_funct3 = 0; bus2.rsp_ready = 1;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.req_funct3 = 0; bus0.rsp_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus2.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus2.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, bus2.rsp_err},   32'd0);
    chk("rst_rsp_rdata", bus2.rsp_rdata, 32'd0);
    chk("rst0_req_ready", {31'b0, bus0.req_ready}, 32'd1);
    rst = 1'b1;

    // Word store/load round trip
    run2("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 1'b0);
    run2("lw_10", 1'b0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 1'b0);

    // Sub-word loads with extension
    run2("sw_10b", 1'b1, 32'h10, 32'h8081F0F0, F3_W, 32'h0, 1'b0);
    run2("lb_13",  1'b0, 32'h13, 32'h0, F3_B,  32'hFFFFFF80, 1'b0);
    run2("lbu_13", 1'b0, 32'h13, 32'h0, F3_BU, 32'h00000080, 1'b0);
    run2("lh_12",  1'b0, 32'h12, 32'h0, F3_H,  32'hFFFF8081, 1'b0);
    run2("lhu_10", 1'b0, 32'h10, 32'h0, F3_HU, 32'h0000F0F0, 1'b0);

    // Misaligned store rejected, memory untouched
    run2("sh_11", 1'b1, 32'h11, 32'h00001234, F3_H, 32'h0, 1'b1);
    run2("lw_after_sh11", 1'b0, 32'h10, 32'h0, F3_W, 32'h8081F0F0, 1'b0);

    // Byte and half stores hit only their lanes
    run2("sb_11", 1'b1, 32'h11, 32'hFFFFFFAB, F3_B, 32'h0, 1'b0);
    run2("sh_12", 1'b1, 32'h12, 32'h00005555, F3_H, 32'h0, 1'b0);
    run2("lw_lanes", 1'b0, 32'h10, 32'h0, F3_W, 32'h5555ABF0, 1'b0);
    run2("lb_11", 1'b0, 32'h11, 32'h0, F3_B, 32'hFFFFFFAB, 1'b0);

    // Other error cases
    run2("sbu_store", 1'b1, 32'h10, 32'h0, F3_BU, 32'h0, 1'b1);
    run2("lw_oor", 1'b0, 32'h400, 32'h0, F3_W, 32'h0, 1'b1);
    run2("f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    run2("lw_mis", 1'b0, 32'h12, 32'h0, F3_W, 32'h0, 1'b1);
    run2("lw_unchanged", 1'b0, 32'h10, 32'h0, F3_W, 32'h5555ABF0, 1'b0);

    // Back-pressure: response held stable while rsp_ready is low
    @(negedge clk);
    bus2.req_valid = 1; bus2.req_we = 0; bus2.req_addr = 32'h10; bus2.req_funct3 = F3_W;
    bus2.rsp_ready = 0;
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 0;
    n = 0;
    while (bus2.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    held = bus2.rsp_rdata;
    chk("stall_rdata", held, 32'h5555ABF0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, bus2.rsp_valid}, 32'd1);
      chk("stall_hold",  bus2.rsp_rdata, 32'h5555ABF0);
      chk("stall_ready", {31'b0, bus2.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus2.rsp_ready = 1;
    @(negedge clk);
    chk("stall_release_valid", {31'b0, bus2.rsp_valid}, 32'd0);
    chk("stall_release_ready", {31'b0, bus2.req_ready}, 32'd1);

    // Reset during WAIT abandons the store
    run2("sw_20_zero", 1'b1, 32'h20, 32'h0, F3_W, 32'h0, 1'b0);
    @(negedge clk);
    bus2.req_valid = 1; bus2.req_we = 1; bus2.req_addr = 32'h20;
    bus2.req_wdata = 32'h12345678; bus2.req_funct3 = F3_W;
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 0;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    chk("wrst_valid", {31'b0, bus2.rsp_valid}, 32'd0);
    chk("wrst_ready", {31'b0, bus2.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("wrst_no_rsp", {31'b0, bus2.rsp_valid}, 32'd0);
    run2("lw_20", 1'b0, 32'h20, 32'h0, F3_W, 32'h0, 1'b0);

    // Reset on the commit edge suppresses the store
    run2("sw_24_zero", 1'b1, 32'h24, 32'h0, F3_W, 32'h0, 1'b0);
    @(negedge clk);
    bus2.req_valid = 1; bus2.req_we = 1; bus2.req_addr = 32'h24;
    bus2.req_wdata = 32'hCAFEF00D; bus2.req_funct3 = F3_W;
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    chk("crst_valid", {31'b0, bus2.rsp_valid}, 32'd0);
    run2("lw_24", 1'b0, 32'h24, 32'h0, F3_W, 32'h0, 1'b0);

    // LATENCY=0 instance: one-cycle response, then back-to-back loads
    @(negedge clk);
    bus0.req_valid = 1; bus0.req_we = 1; bus0.req_addr = 32'h8;
    bus0.req_wdata = 32'h11223344; bus0.req_funct3 = F3_W; bus0.rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("l0_sw_valid", {31'b0, bus0.rsp_valid}, 32'd1);
    chk("l0_sw_err",   {31'b0, bus0.rsp_err},   32'd0);
    bus0.req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1; bus0.req_we = 0; bus0.req_addr = 32'h8; bus0.req_funct3 = F3_W;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("l0_b2b_valid", {31'b0, bus0.rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("l0_b2b_ready", {31'b0, bus0.req_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) chk("l0_b2b_rdata", bus0.rsp_rdata, 32'h11223344);
    end
    bus0.req_valid = 0;
    @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
